// File: rtl/result_arb_pkg.sv
// Shared types and constants for the result write arbiter.
package result_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int unsigned DEF_BUF_DEPTH = 20;
    localparam int unsigned OCC_W         = $clog2(DEF_BUF_DEPTH + 1);

    // Timestamp field inside a result word; carried through untouched.
    localparam int unsigned TS_LO = 16;
    localparam int unsigned TS_HI = 79;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Arbitrates NUM_REQ producers onto one result buffer, pacing writes and tracking credits.
// Optional macro RESULT_ARB_PRIO0_EN gives requester 0 absolute priority.
module result_write_arbiter
    import result_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RESULT_SIZE = 88,
    parameter int unsigned BUF_DEPTH   = 20,
    parameter int unsigned WRITE_GAP   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*RESULT_SIZE-1:0]     req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [RESULT_SIZE-1:0]             buf_data,
    output logic                               buf_valid,
    input  logic                               buf_drain,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy,
    output logic                               err_underflow
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned OCC_WL   = occ_width(BUF_DEPTH);
    localparam int unsigned GAP_W    = $clog2(WRITE_GAP + 1);
    localparam int unsigned GAP_LOAD = (WRITE_GAP > 1) ? WRITE_GAP - 2 : 0;

    state_t                 state, state_nxt;
    logic [GAP_W-1:0]       gap_cnt, gap_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic [NUM_REQ-1:0]     arb_req, arb_grant, win_grant;
    logic [IDX_W-1:0]       arb_idx, win_idx;
    logic [RESULT_SIZE-1:0] win_data;
    logic [OCC_WL:0]        occ_plus;
    logic                   eligible;
    logic                   accept;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (arb_req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Winner selection and next rotating pointer
    always_comb begin
        arb_req   = req_valid;
        win_grant = arb_grant;
        win_idx   = arb_idx;
        ptr_nxt   = ptr;
`ifdef RESULT_ARB_PRIO0_EN
        arb_req = req_valid & ~NUM_REQ'(1);
        if (req_valid[0]) begin
            win_grant = NUM_REQ'(1);
            win_idx   = '0;
        end
        if (win_idx == '0)
            ptr_nxt = ptr;
        else if (win_idx == IDX_W'(NUM_REQ - 1))
            ptr_nxt = IDX_W'(1);
        else
            ptr_nxt = win_idx + IDX_W'(1);
`else
        if (win_idx == IDX_W'(NUM_REQ - 1))
            ptr_nxt = '0;
        else
            ptr_nxt = win_idx + IDX_W'(1);
`endif
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) win_data = req_data[i*RESULT_SIZE +: RESULT_SIZE];
        end
    end

    // An in-flight strobe already owns a buffer slot
    assign occ_plus = {1'b0, occupancy} + (OCC_WL+1)'(buf_valid);
    assign eligible = (|req_valid) && (occ_plus < (OCC_WL+1)'(BUF_DEPTH));

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        accept    = 1'b0;
        req_ready = '0;
        case (state)
            S_IDLE: begin
                if (eligible) begin
                    accept    = 1'b1;
                    req_ready = win_grant;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (WRITE_GAP > 1) begin
                    gap_nxt   = GAP_W'(GAP_LOAD);
                    state_nxt = S_GAP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0)
                    state_nxt = S_IDLE;
                else
                    gap_nxt = gap_cnt - GAP_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            gap_cnt       <= '0;
            ptr           <= '0;
            buf_valid     <= 1'b0;
            buf_data      <= '0;
            occupancy     <= '0;
            err_underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            buf_valid <= accept;
            if (accept) begin
                ptr      <= ptr_nxt;
                buf_data <= win_data;
            end
            if (buf_valid && !buf_drain)
                occupancy <= occupancy + OCC_WL'(1);
            else if (!buf_valid && buf_drain && occupancy != '0)
                occupancy <= occupancy - OCC_WL'(1);
            if (buf_drain && occupancy == '0)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_write_arbiter.sv
// Directed self-checking bench for result_write_arbiter (default parameters).
module tb_result_write_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned RS      = 88;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*RS-1:0] req_data;
    logic [NUM_REQ-1:0] req_ready;
    logic [RS-1:0]     buf_data;
    logic              buf_valid;
    logic              buf_drain;
    logic [4:0]        occupancy;
    logic              err_underflow;

    int total = 0;
    int bad   = 0;

    result_write_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .buf_data      (buf_data),
        .buf_valid     (buf_valid),
        .buf_drain     (buf_drain),
        .occupancy     (occupancy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [RS-1:0] mk(input int i);
        return {8'(8'hA0 + i), 64'(64'h0123_4567_89AB_CD00 + 64'(i)), 16'(16'hBEE0 + i)};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; buf_drain = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_strobe(output logic [RS-1:0] data, output int waited, output bit ok);
        ok = 1'b0; waited = 0; data = '0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            waited++;
            if (buf_valid) begin
                ok   = 1'b1;
                data = buf_data;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RS-1:0] d;
        int            w;
        bit            ok;
        int            cnt;
        int            ord2[5] = '{0, 1, 2, 3, 0};
        int            ord6[4] = '{1, 2, 3, 1};

        rst = 1'b1; req_valid = '0; buf_drain = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*RS +: RS] = mk(i);
        do_reset();

        // reset state
        chk("rst_ready", 96'(req_ready), 96'(0));
        chk("rst_valid", 96'(buf_valid), 96'(0));
        chk("rst_data", 96'(buf_data), 96'(0));
        chk("rst_occ", 96'(occupancy), 96'(0));
        chk("rst_err", 96'(err_underflow), 96'(0));

        // single requester
        req_valid = 4'b0100;
        #1 chk("t1_ready", 96'(req_ready), 96'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        chk("t1_valid", 96'(buf_valid), 96'(1));
        chk("t1_data", 96'(buf_data), 96'(mk(2)));
        @(negedge clk);
        chk("t1_occ", 96'(occupancy), 96'(1));
        chk("t1_valid_off", 96'(buf_valid), 96'(0));

`ifndef RESULT_ARB_PRIO0_EN
        // round robin order and strobe spacing
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_strobe(d, w, ok);
            chk("t2_timeout", 96'(ok), 96'(1));
            chk("t2_data", 96'(d), 96'(mk(ord2[k])));
            if (k > 0) chk("t2_gap", 96'(w), 96'(4));
        end
`endif

        // fill the buffer, then free one slot
        do_reset();
        req_valid = 4'hF;
        cnt = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (buf_valid) cnt++;
        end
        chk("t3_writes", 96'(cnt), 96'(20));
        chk("t3_occ_full", 96'(occupancy), 96'(20));
        chk("t3_ready_full", 96'(req_ready), 96'(0));
        buf_drain = 1'b1;
        @(negedge clk);
        buf_drain = 1'b0;
        chk("t3_occ_drain", 96'(occupancy), 96'(19));
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (buf_valid) cnt++;
        end
        chk("t3_one_more", 96'(cnt), 96'(1));
        chk("t3_occ_refill", 96'(occupancy), 96'(20));

        // simultaneous write and drain at occupancy 5
        do_reset();
        req_valid = 4'hF;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (buf_valid && occupancy == 5'd5) begin
                ok        = 1'b1;
                req_valid = '0;
                buf_drain = 1'b1;
            end
        end
        chk("t4_sync_timeout", 96'(ok), 96'(1));
        @(negedge clk);
        buf_drain = 1'b0;
        chk("t4_occ_same", 96'(occupancy), 96'(5));

        // underflow
        do_reset();
        buf_drain = 1'b1;
        @(negedge clk);
        buf_drain = 1'b0;
        chk("t4_occ_zero", 96'(occupancy), 96'(0));
        chk("t4_err", 96'(err_underflow), 96'(1));
        @(negedge clk);
        chk("t4_err_sticky", 96'(err_underflow), 96'(1));
        do_reset();
        chk("t4_err_clr", 96'(err_underflow), 96'(0));

        // reset landing on an accept
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("t5_occ_pre", 96'(occupancy), 96'(1));
        req_valid = 4'b0010;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        chk("t5_no_valid", 96'(buf_valid), 96'(0));
        chk("t5_occ", 96'(occupancy), 96'(0));
        req_valid = 4'b1001;
        #1 chk("t5_ready_low", 96'(req_ready), 96'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        chk("t5_data", 96'(buf_data), 96'(mk(0)));

`ifdef RESULT_ARB_PRIO0_EN
        // requester 0 priority
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(d, w, ok);
            chk("t6_timeout", 96'(ok), 96'(1));
            chk("t6_prio_data", 96'(d), 96'(mk(0)));
        end
        req_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(d, w, ok);
            chk("t6_timeout", 96'(ok), 96'(1));
            chk("t6_rr_data", 96'(d), 96'(mk(ord6[k])));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
